// File: rtl/cmp_pkg.sv
// ==== cmp_pkg : shared state encoding and slice-count constants for cmp_seq ====
// ==== rev 1.0                                                              ====
`default_nettype none

package cmp_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int W_DEFAULT = 8;
  localparam int S_DEFAULT = 2;
  localparam int NSLICE    = W_DEFAULT / S_DEFAULT;
  localparam int CNT_W     = $clog2(NSLICE);

  function automatic int calc_nslice(input int w, input int s);
    return w / s;
  endfunction

  // Counter must hold NSLICE-1; keep at least one bit for the degenerate case.
  function automatic int calc_cnt_w(input int w, input int s);
    return ((w / s) > 1) ? $clog2(w / s) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_slice.sv
// ==== cmp_slice : combinational unsigned S-bit equal / greater-than compare ====
// ==== rev 1.0                                                              ====
`default_nettype none

module cmp_slice #(
  parameter int S = 2
) (
  input  logic [S-1:0] x,
  input  logic [S-1:0] y,
  output logic         eq,
  output logic         gt
);

  assign eq = (x == y);
  assign gt = (x > y);

endmodule

`default_nettype wire

// File: rtl/cmp_seq.sv
// ==== cmp_seq : sequential MSB-first magnitude comparator, early exit on first differing slice ====
// ==== rev 1.0                                                                                 ====
`default_nettype none

module cmp_seq
  import cmp_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         aeqb,
  output logic         agtb,
  output logic         altb
);

  localparam int NSL = calc_nslice(W, S);
  localparam int CW  = calc_cnt_w(W, S);

  state_t         state, state_n;
  logic [W-1:0]   sa, sa_n, sb, sb_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           busy_n, done_n, aeqb_n, agtb_n, altb_n;
  logic           slice_eq, slice_gt;

  cmp_slice #(.S(S)) u_slice (
    .x  (sa[W-1 -: S]),
    .y  (sb[W-1 -: S]),
    .eq (slice_eq),
    .gt (slice_gt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      aeqb  <= 1'b0;
      agtb  <= 1'b0;
      altb  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      aeqb  <= aeqb_n;
      agtb  <= agtb_n;
      altb  <= altb_n;
    end
  end

  // Results hold by default; done is a pulse so it defaults low.
  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    aeqb_n  = aeqb;
    agtb_n  = agtb;
    altb_n  = altb;
    unique case (state)
      IDLE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = b;
          cnt_n   = CW'(NSL - 1);
          aeqb_n  = 1'b0;
          agtb_n  = 1'b0;
          altb_n  = 1'b0;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!slice_eq) begin
          agtb_n  = slice_gt;
          altb_n  = !slice_gt;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end else if (cnt != '0) begin
          sa_n  = sa << S;
          sb_n  = sb << S;
          cnt_n = cnt - CW'(1);
        end else begin
          aeqb_n  = 1'b1;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cmp_seq.sv
// ==== tb_cmp_seq : directed self-checking bench for cmp_seq (W=8, S=2) ====
// ==== rev 1.0                                                          ====
`default_nettype none

module tb_cmp_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, aeqb, agtb, altb;
  logic [2:0] res;
  int         checks = 0;
  int         failures = 0;

  cmp_seq #(.W(8), .S(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .aeqb    (aeqb),
    .agtb    (agtb),
    .altb    (altb)
  );

  always #5 clk = ~clk;
  assign res = {aeqb, agtb, altb};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, res} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 00000", {busy, done, res});
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({busy, done, res} !== 5'b0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 00000", {busy, done, res});
    end
  endtask

  task automatic test_equal();
    int lat;
    int bad_busy;
    start = 1'b1; a = 8'hA5; b = 8'hA5;
    tick();
    start = 1'b0; a = 8'h00; b = 8'hFF;
    checks++;
    if ({busy, done, res} !== 5'b10000) begin
      failures++;
      $display("FAIL equal_accept: got %b expected 10000", {busy, done, res});
    end
    lat = 0; bad_busy = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) bad_busy++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL equal_latency: got %0d expected 4", lat);
    end
    checks++;
    if (bad_busy !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL equal_busy: drops %0d busy_at_done %b expected 0 0", bad_busy, busy);
    end
    checks++;
    if (res !== 3'b100) begin
      failures++;
      $display("FAIL equal_result: got %b expected 100", res);
    end
    tick();
    checks++;
    if (done !== 1'b0 || res !== 3'b100) begin
      failures++;
      $display("FAIL equal_pulse: done %b res %b expected 0 100", done, res);
    end
  endtask

  task automatic test_gt_msb();
    int lat;
    start = 1'b1; a = 8'h80; b = 8'h7F;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL gt_latency: got %0d expected 1", lat);
    end
    checks++;
    if (res !== 3'b010 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gt_result: res %b busy %b expected 010 0", res, busy);
    end
    tick();
  endtask

  task automatic test_lt_lsb_hold();
    int lat;
    start = 1'b1; a = 8'h12; b = 8'h13;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL lt_latency: got %0d expected 4", lat);
    end
    checks++;
    if (res !== 3'b001) begin
      failures++;
      $display("FAIL lt_result: got %b expected 001", res);
    end
    a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({busy, done, res} !== 5'b00001) begin
        failures++;
        $display("FAIL lt_hold[%0d]: got %b expected 00001", i, {busy, done, res});
      end
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start = 1'b1; a = 8'h00; b = 8'h00;
    tick();
    start = 1'b1; a = 8'hFF; b = 8'h00;
    tick();
    start = 1'b0;
    lat = 1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_state: busy %b done %b expected 1 0", busy, done);
    end
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL busy_ignore_latency: got %0d expected 4", lat);
    end
    checks++;
    if (res !== 3'b100) begin
      failures++;
      $display("FAIL busy_ignore_result: got %b expected 100", res);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    int lat;
    int spurious;
    start = 1'b1; a = 8'h33; b = 8'h33;
    tick();
    start = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, res} !== 5'b0) begin
      failures++;
      $display("FAIL abort_async: got %b expected 00000", {busy, done, res});
    end
    tick();
    reset_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      failures++;
      $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious);
    end
    start = 1'b1; a = 8'h01; b = 8'h02;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 4 || res !== 3'b001) begin
      failures++;
      $display("FAIL abort_restart: lat %0d res %b expected 4 001", lat, res);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; a = 8'h40; b = 8'h80;
    tick();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_accept1: busy %b done %b expected 1 0", busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || res !== 3'b001) begin
      failures++;
      $display("FAIL b2b_done1: done %b res %b expected 1 001", done, res);
    end
    a = 8'h80; b = 8'h40;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, res} !== 5'b10000) begin
      failures++;
      $display("FAIL b2b_accept2: got %b expected 10000", {busy, done, res});
    end
    tick();
    checks++;
    if (done !== 1'b1 || res !== 3'b010) begin
      failures++;
      $display("FAIL b2b_done2: done %b res %b expected 1 010", done, res);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_gt_msb();
    test_lt_lsb_hold();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmp_seq.md
CMP_SEQ -- requirements
Module: cmp_seq

Interface
REQ-001 SHALL have parameter W, default 8: operand width in bits.
REQ-002 SHALL have parameter S, default 2: slice width compared per cycle; W divisible by S, W/S >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a comparison; sampled only in IDLE.
REQ-006 SHALL have port a  input  W  operand A, unsigned; sampled on the accepting edge.
REQ-007 SHALL have port b  input  W  operand B, unsigned; sampled on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port aeqb  output  1  result: A equals B.
REQ-011 SHALL have port agtb  output  1  result: A greater than B.
REQ-012 SHALL have port altb  output  1  result: A less than B.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-014 On an edge in IDLE with start=1: latch a and b into shift registers, load slice counter with W/S-1, clear aeqb/agtb/altb, go to RUN, busy=1 from that edge.
REQ-015 In RUN, each edge SHALL compare the MSB-most unconsumed S-bit slices of the latched operands, unsigned.
REQ-016 Slices unequal: register agtb or altb per that slice, assert done, go to IDLE; this is an early exit.
REQ-017 Slices equal with counter>0: shift both registers left by S, decrement counter, stay in RUN.
REQ-018 Slices equal with counter=0: register aeqb=1, assert done, go to IDLE.
REQ-019 Latency from the accepting edge to the edge that raises done SHALL be k+1 cycles for first differing slice k (k=0 is the MSB slice), and W/S cycles for equal operands.
REQ-020 busy SHALL fall on the same edge that raises done.
REQ-021 done SHALL be high for exactly one cycle.
REQ-022 Exactly one of aeqb/agtb/altb SHALL be high from done until the next accepted start; all three are low between an accepted start and done.
REQ-023 Results SHALL hold while idle with no start.
REQ-024 start while busy=1 SHALL be ignored: no relatch, no extension, no effect on results.
REQ-025 start high in the cycle done is high SHALL be accepted, because the FSM is already in IDLE, giving back-to-back operation.
REQ-026 a and b SHALL have no effect on results after the accepting edge.

Reset
REQ-027 reset_n low SHALL immediately, without clk, force IDLE, busy=0, done=0, aeqb=agtb=altb=0, counter=0 and shift registers=0.
REQ-028 Reset asserted mid-comparison SHALL abort it with no done pulse; the first start after deassertion SHALL be accepted normally.

Structure
REQ-029 The state encoding (IDLE, RUN) and the derived constant NSLICE=W/S with its counter width clog2(NSLICE) SHALL live in a shared package cmp_pkg.
REQ-030 The per-slice unsigned compare (S-bit eq/gt, combinational) SHALL be a sub-module cmp_slice, instantiated once.
REQ-031 All outputs SHALL be registered.

Verification (W=8, S=2)
REQ-032 a=8'hA5, b=8'hA5, start 1 cycle -> busy 4 cycles, done on 4th edge, aeqb=1, agtb=altb=0.
REQ-033 a=8'h80, b=8'h7F -> done 1 edge after accept, agtb=1.
REQ-034 a=8'h12, b=8'h13 -> done 4 edges after accept, altb=1; results then held 10 idle cycles.
REQ-035 Start a=8'h00/b=8'h00; 1 cycle later assert start with a=8'hFF/b=8'h00 -> second start ignored, aeqb=1 after 4 cycles.
REQ-036 Start a=8'h33/b=8'h33, reset_n low for 1 cycle at cycle 2 -> all outputs 0 immediately, no done; then a=8'h01/b=8'h02 -> altb=1 after 4 cycles.
REQ-037 start held high across a done cycle with a=8'h40/b=8'h80 then a=8'h80/b=8'h40 -> two done pulses 1 cycle apart, altb then agtb.
